pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into NSTAGE = WIDTH/GROUP lookahead groups, with one group resolved per pipeline stage.
- Uses a valid/ready handshake on both sides and a global stall under output backpressure.
- Serves as the datapath adder in the ALU, replacing the fixed 8-bit combinational carry chain.

---
 rtl/pipelined_cla_adder.sv | 153 +++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group resolved per stage.
// Define CLA_FLAGS_EN to add the registered ovf (signed overflow) and zero flags.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NSTAGE = WIDTH / GROUP;

    typedef struct packed {
        logic [GROUP-1:0] s;
        logic             co;
        logic             cm;
    } grp_t;

    // cm is the carry into the group's top bit; only the last group's value matters (for ovf)
    function automatic grp_t cla_group(input logic [GROUP-1:0] x,
                                       input logic [GROUP-1:0] y,
                                       input logic             ci);
        grp_t             r;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic             c;
        r = '0;
        p = x ^ y;
        g = x & y;
        c = ci;
        for (int i = 0; i < GROUP; i++) begin
            r.s[i] = p[i] ^ c;
            if (i == GROUP - 1) r.cm = c;
            c = g[i] | (p[i] & c);
        end
        r.co = c;
        return r;
    endfunction

    logic stall;

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        logic             vld_p;
        logic [WIDTH-1:0] sum_p;
        logic [WIDTH-1:0] a_p;
        logic [WIDTH-1:0] bb_p;
        logic             c_p;

        logic             src_vld;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_bb;
        logic             src_c;

        logic [GROUP-1:0] grp_s;
        logic             grp_co;
        logic             grp_cm;
        logic [WIDTH-1:0] nxt_sum;
        logic             unused_cm;

        if (k == 0) begin : g_in
            assign src_vld = in_valid & in_ready;
            assign src_sum = '0;
            assign src_a   = a;
            assign src_bb  = sub ? ~b : b;
            assign src_c   = sub | cin;
        end else begin : g_mid
            assign src_vld = stg[k-1].vld_p;
            assign src_sum = stg[k-1].sum_p;
            assign src_a   = stg[k-1].a_p;
            assign src_bb  = stg[k-1].bb_p;
            assign src_c   = stg[k-1].c_p;
        end

        always_comb begin
            grp_t r;
            r       = cla_group(src_a[k*GROUP +: GROUP], src_bb[k*GROUP +: GROUP], src_c);
            grp_s   = r.s;
            grp_co  = r.co;
            grp_cm  = r.cm;
            nxt_sum = src_sum;
            nxt_sum[k*GROUP +: GROUP] = r.s;
        end

        assign unused_cm = grp_cm;

        // Stage k boundary: data only loads with a valid op so idle outputs stay stable
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                sum_p <= '0;
                c_p   <= 1'b0;
            end else if (!stall) begin
                vld_p <= src_vld;
                if (src_vld) begin
                    sum_p <= nxt_sum;
                    c_p   <= grp_co;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!stall && src_vld) begin
                a_p  <= src_a;
                bb_p <= src_bb;
            end
        end
    end

    assign out_valid = stg[NSTAGE-1].vld_p;
    assign sum       = stg[NSTAGE-1].sum_p;
    assign cout      = stg[NSTAGE-1].c_p;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    logic unused_ops;
    assign unused_ops = ^{stg[NSTAGE-1].a_p, stg[NSTAGE-1].bb_p};

`ifdef CLA_FLAGS_EN
    logic ovf_p;
    logic zero_p;

    // Flags register in step with the final stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p  <= 1'b0;
            zero_p <= 1'b0;
        end else if (!stall && stg[NSTAGE-1].src_vld) begin
            ovf_p  <= stg[NSTAGE-1].grp_co ^ stg[NSTAGE-1].grp_cm;
            zero_p <= (stg[NSTAGE-1].nxt_sum == '0);
        end
    end

    assign ovf  = ovf_p;
    assign zero = zero_p;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: 32/8, 8/8 and 16/4 instances against an arithmetic model.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 32-bit / 8-bit groups
    logic        iv, ir, ov, ordy, cin, sub, cout;
    logic [31:0] a, b, sum;
    // 8-bit / 8-bit groups
    logic        iv8, ir8, ov8, ordy8, cin8, sub8, cout8;
    logic [7:0]  a8, b8, sum8;
    // 16-bit / 4-bit groups
    logic        iv16, ir16, ov16, ordy16, cin16, sub16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef CLA_FLAGS_EN
    logic ovf, zero, ovf8, zero8, ovf16, zero16;
`endif

    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout)
`ifdef CLA_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .cout(cout8)
`ifdef CLA_FLAGS_EN
        , .ovf(ovf8), .zero(zero8)
`endif
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16), .cout(cout16)
`ifdef CLA_FLAGS_EN
        , .ovf(ovf16), .zero(zero16)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci_in, input logic sb);
        exp_t        e;
        logic [31:0] bb;
        logic        ci;
        logic [32:0] full;
        longint      sv;
        bb   = sb ? ~y : y;
        ci   = sb ? 1'b1 : ci_in;
        full = {1'b0, x} + {1'b0, bb} + 33'(ci);
        sv   = longint'($signed(x)) + longint'($signed(bb)) + longint'(ci);
        e.s  = full[31:0];
        e.c  = full[32];
        e.o  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        e.z  = (full[31:0] == 32'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv = 0; iv8 = 0; iv16 = 0;
        ordy = 1; ordy8 = 1; ordy16 = 1;
        a = '0; b = '0; cin = 0; sub = 0;
        a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
        a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
        checks++; if (sum !== 32'd0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir); end
        checks++; if (ov8 !== 1'b0 || ov16 !== 1'b0) begin failures++; $display("FAIL reset_small_valid got=%b%b exp=00", ov8, ov16); end
`ifdef CLA_FLAGS_EN
        checks++; if (ovf !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf, zero); end
`endif
    endtask

    task automatic test_directed();
        logic [31:0] ta[6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd5, 32'h7FFF_FFFF};
        logic [31:0] tb[6] = '{32'h0000_0001, 32'h0, 32'h0000_0001, 32'd5, 32'd5, 32'h0000_0001};
        logic        tc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] es[6] = '{32'h0000_0100, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h8000_0000};
        logic        ec[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        eo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ez[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int n;
        ordy = 1;
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i]; iv = 1;
            @(posedge clk);
            #1;
            iv = 0;
            n = 0;
            while (!ov && n < 10) begin tick(); n++; end
            checks++; if (n != 3) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=3", i, n); end
            checks++; if (sum !== es[i]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, ec[i]); end
`ifdef CLA_FLAGS_EN
            checks++; if (ovf !== eo[i]) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
            checks++; if (zero !== ez[i]) begin failures++; $display("FAIL dir%0d_zero got=%b exp=%b", i, zero, ez[i]); end
`else
            if (eo[i] === 1'bx || ez[i] === 1'bx) $display("note: bad table entry %0d", i);
`endif
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa[6], ob[6];
        logic        oc[6], os[6];
        exp_t        q[$];
        exp_t        e;
        int idx = 0, got = 0, stall_left = 0, stalled = 0;
        bit trig = 0;
        logic exp_ir;
        for (int i = 0; i < 6; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; oc[i] = 1'($urandom); os[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (!trig && ov) begin trig = 1; stall_left = 3; end
            ordy = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (idx < 6) begin
                iv = 1; a = oa[idx]; b = ob[idx]; cin = oc[idx]; sub = os[idx];
            end else begin
                iv = 0;
            end
            #1;
            exp_ir = !(ov && !ordy);
            checks++; if (ir !== exp_ir) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, ir, exp_ir); end
            if (!ir) stalled++;
            if (iv && ir) begin q.push_back(model32(a, b, cin, sub)); idx++; end
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_extra_result got=%h exp=none", sum);
                end else begin
                    e = q.pop_front();
                    checks++; if (sum !== e.s || cout !== e.c) begin failures++; $display("FAIL b2b_result%0d got=%b_%h exp=%b_%h", got, cout, sum, e.c, e.s); end
`ifdef CLA_FLAGS_EN
                    checks++; if (ovf !== e.o || zero !== e.z) begin failures++; $display("FAIL b2b_flags%0d got=%b%b exp=%b%b", got, ovf, zero, e.o, e.z); end
`endif
                end
                got++;
            end
            tick();
        end
        iv = 0; ordy = 1;
        checks++; if (got != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", got); end
        checks++; if (stalled != 3) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalled); end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        ordy = 1;
        for (int i = 0; i < 3; i++) begin
            iv = 1; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        iv = 0;
        rst_n = 1'b0;
        tick();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", ov); end
        checks++; if (sum !== 32'd0) begin failures++; $display("FAIL midrst_sum got=%h exp=0", sum); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", seen); end
    endtask

    task automatic test_sweep();
        logic [8:0]  q8[$];
        logic [16:0] q16[$];
        logic [8:0]  e8, f8;
        logic [16:0] e16, f16;
        logic [7:0]  bb8;
        logic [15:0] bb16;
        int iss8 = 0, iss16 = 0, got8 = 0, got16 = 0;
        bit clr8 = 0, clr16 = 0;
        for (int cyc = 0; cyc < 20000 && (got8 < 1000 || got16 < 1000); cyc++) begin
            if (clr8) begin iv8 = 0; clr8 = 0; end
            if (clr16) begin iv16 = 0; clr16 = 0; end
            if (!iv8 && iss8 < 1000 && $urandom_range(0, 3) != 0) begin
                iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            end
            if (!iv16 && iss16 < 1000 && $urandom_range(0, 3) != 0) begin
                iv16 = 1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
            end
            ordy8 = ($urandom_range(0, 3) != 0);
            ordy16 = ($urandom_range(0, 3) != 0);
            #1;
            if (iv8 && ir8) begin
                bb8 = sub8 ? ~b8 : b8;
                f8 = {1'b0, a8} + {1'b0, bb8} + 9'(sub8 ? 1'b1 : cin8);
                q8.push_back(f8); iss8++; clr8 = 1;
            end
            if (iv16 && ir16) begin
                bb16 = sub16 ? ~b16 : b16;
                f16 = {1'b0, a16} + {1'b0, bb16} + 17'(sub16 ? 1'b1 : cin16);
                q16.push_back(f16); iss16++; clr16 = 1;
            end
            if (ov8 && ordy8) begin
                e8 = (q8.size() != 0) ? q8.pop_front() : 9'h1xx;
                checks++; if ({cout8, sum8} !== e8) begin failures++; $display("FAIL sweep8_op%0d got=%h exp=%h", got8, {cout8, sum8}, e8); end
                got8++;
            end
            if (ov16 && ordy16) begin
                e16 = (q16.size() != 0) ? q16.pop_front() : 17'h1xxxx;
                checks++; if ({cout16, sum16} !== e16) begin failures++; $display("FAIL sweep16_op%0d got=%h exp=%h", got16, {cout16, sum16}, e16); end
                got16++;
            end
            tick();
        end
        iv8 = 0; iv16 = 0; ordy8 = 1; ordy16 = 1;
        checks++; if (got8 != 1000) begin failures++; $display("FAIL sweep8_count got=%0d exp=1000", got8); end
        checks++; if (got16 != 1000) begin failures++; $display("FAIL sweep16_count got=%0d exp=1000", got16); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
